// File: rtl/usr_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : usr_shift_ctrl
//  Purpose  : Upstream sequencer for a 4-bit universal shift register. It
//             loads each accepted nibble into the USR and shifts it out
//             serially. Optional macro: USR_SHIFT_CTRL_PARITY_EN adds a
//             trailing even-parity bit to each frame.
//  Revision : 1.0 - initial release
// ============================================================================
module usr_shift_ctrl #(
    parameter int GAP = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_dir,
    input  logic       hold,
    output logic [1:0] mode,
    output logic [3:0] par_in,
    output logic       SI,
    output logic       busy,
    output logic       bit_valid,
    output logic       done
);

`ifdef USR_SHIFT_CTRL_PARITY_EN
    localparam int NBITS = 5;
`else
    localparam int NBITS = 4;
`endif

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_GAPW  = 3'd4;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SR    = 2'b01;
    localparam logic [1:0] MODE_SL    = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [2:0] LAST_BIT = 3'(NBITS - 1);
    localparam logic [3:0] LAST_GAP = 4'(GAP - 1);
    localparam bit         HAS_GAP  = (GAP > 0);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic       dir;
    logic       alive;
    logic       accept;
    logic       shift_step;

    // alive keeps in_ready low until the first edge that sees rstn high
    assign in_ready   = alive && (state == ST_IDLE);
    assign accept     = in_valid && in_ready;
    assign shift_step = (state == ST_SHIFT) && !hold;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_step && (bit_cnt == LAST_BIT)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = HAS_GAP ? ST_GAPW : ST_IDLE;
            end
            ST_GAPW: begin
                if (gap_cnt == LAST_GAP) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            gap_cnt <= 4'd0;
            dir     <= 1'b0;
            par_in  <= 4'd0;
            alive   <= 1'b0;
        end else begin
            alive <= 1'b1;
            state <= state_nxt;
            if (accept) begin
                par_in <= in_data;
                dir    <= in_dir;
            end
            case (state)
                ST_LOAD: begin
                    bit_cnt <= 3'd0;
                end
                ST_SHIFT: begin
                    if (shift_step && (bit_cnt != LAST_BIT)) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    gap_cnt <= 4'd0;
                end
                ST_GAPW: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // hold acts combinationally so the USR freezes in the same cycle
    always_comb begin
        mode = MODE_HOLD;
        case (state)
            ST_LOAD: begin
                mode = MODE_LOAD;
            end
            ST_SHIFT: begin
                if (!hold) begin
                    mode = dir ? MODE_SL : MODE_SR;
                end
            end
            default: begin
                mode = MODE_HOLD;
            end
        endcase
    end

    assign bit_valid = shift_step;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

`ifdef USR_SHIFT_CTRL_PARITY_EN
    // parity enters the far end on the first shift and exits as the last bit
    assign SI = (state == ST_SHIFT) && (bit_cnt == 3'd0) && (^par_in);
`else
    assign SI = 1'b0;
`endif

endmodule
`default_nettype wire
